multicycle_alu: RTL and testbench



---
 rtl/multicycle_alu.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Registered ALU with a start/ready/done handshake. Single-cycle ops complete on the accept edge,
// while multiply (shift-add) and divide/remainder (restoring) take WIDTH iterations.
module multicycle_alu #(
  parameter int WIDTH     = 32,
  parameter int SHAMT_LSB = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DIV  = 2'b10;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADD3 = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;
  localparam logic [3:0] OP_ADDF = 4'b1111;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]    CNT_LAST = SW'(WIDTH - 1);
  localparam logic [SW-1:0]    CNT_ONE  = {{(SW-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [SW-1:0]    cnt_r;
  logic             rem_sel_r;
  logic [WIDTH-1:0] opnd_r;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_r;     // partial product high word or running remainder
  logic [WIDTH-1:0] lo_r;     // multiplier/product low word or dividend/quotient
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_hi_r;
  logic             zero_r;
  logic             done_r;
  logic             ready_r;

  logic [SW-1:0]    sh_s;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_hi_next_s;
  logic [WIDTH-1:0] mul_lo_next_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_rem_next_s;
  logic [WIDTH-1:0] div_quo_next_s;

  assign sh_s = b[SHAMT_LSB +: SW];

  // Single-cycle operation result; iterative opcodes never use this value.
  always_comb begin
    alu_s = ZERO_W;
    case (alu_control)
      OP_AND:                   alu_s = a & b;
      OP_OR:                    alu_s = a | b;
      OP_ADD, OP_ADD3, OP_ADDF: alu_s = a + b;
      OP_XOR:                   alu_s = a ^ b;
      OP_SUB:                   alu_s = a - b;
      OP_NOR:                   alu_s = ~(a | b);
      OP_SLTU:                  alu_s = (a < b) ? ONE_W : ZERO_W;
      OP_SLT:                   alu_s = ($signed(a) < $signed(b)) ? ONE_W : ZERO_W;
      OP_SLL:                   alu_s = a << sh_s;
      OP_SRL:                   alu_s = a >> sh_s;
      OP_SRA:                   alu_s = $signed(a) >>> sh_s;
      default:                  alu_s = ZERO_W;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand, then shift the pair right.
  always_comb begin
    if (lo_r[0]) begin
      mul_sum_s = {1'b0, hi_r} + {1'b0, opnd_r};
    end else begin
      mul_sum_s = {1'b0, hi_r};
    end
    mul_hi_next_s = mul_sum_s[WIDTH:1];
    mul_lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
  end

  // One restoring-division step; a zero divisor naturally yields all-ones quotient and remainder = a.
  always_comb begin
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
    if (div_ge_s) begin
      div_rem_next_s = div_diff_s;
      div_quo_next_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_next_s = div_shift_s[WIDTH-1:0];
      div_quo_next_s = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {SW{1'b0}};
      rem_sel_r   <= 1'b0;
      opnd_r      <= ZERO_W;
      hi_r        <= ZERO_W;
      lo_r        <= ZERO_W;
      result_r    <= ZERO_W;
      result_hi_r <= ZERO_W;
      zero_r      <= 1'b1;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && ready_r) begin
            case (alu_control)
              OP_MUL: begin
                state_r <= MUL;
                ready_r <= 1'b0;
                cnt_r   <= {SW{1'b0}};
                opnd_r  <= a;
                hi_r    <= ZERO_W;
                lo_r    <= b;
              end
              OP_DIVU, OP_REMU: begin
                state_r   <= DIV;
                ready_r   <= 1'b0;
                cnt_r     <= {SW{1'b0}};
                rem_sel_r <= (alu_control == OP_REMU);
                opnd_r    <= b;
                hi_r      <= ZERO_W;
                lo_r      <= a;
              end
              default: begin
                result_r    <= alu_s;
                result_hi_r <= ZERO_W;
                zero_r      <= (alu_s == ZERO_W);
                done_r      <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          hi_r  <= mul_hi_next_s;
          lo_r  <= mul_lo_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            cnt_r       <= {SW{1'b0}};
            result_r    <= mul_lo_next_s;
            result_hi_r <= mul_hi_next_s;
            zero_r      <= (mul_lo_next_s == ZERO_W);
            done_r      <= 1'b1;
          end
        end
        DIV: begin
          hi_r  <= div_rem_next_s;
          lo_r  <= div_quo_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            cnt_r       <= {SW{1'b0}};
            result_hi_r <= div_rem_next_s;
            done_r      <= 1'b1;
            if (rem_sel_r) begin
              result_r <= div_rem_next_s;
              zero_r   <= (div_rem_next_s == ZERO_W);
            end else begin
              result_r <= div_quo_next_s;
              zero_r   <= (div_quo_next_s == ZERO_W);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          cnt_r   <= {SW{1'b0}};
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign done      = done_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomised self-checking bench for multicycle_alu against a plain-arithmetic reference model.
module tb_multicycle_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    alu_control = 4'b0000;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ready;
  logic          done;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          zero;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.WIDTH(W), .SHAMT_LSB(6)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .ready(ready), .done(done), .result(result),
    .result_hi(result_hi), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [31:0] hi);
    int unsigned sh;
    logic [63:0] p;
    sh = (y >> 6) & 32'd31;
    hi = 32'd0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0100: r = x ^ y;
      4'b0110: r = x - y;
      4'b1100: r = ~(x | y);
      4'b0111: r = (x < y) ? 32'd1 : 32'd0;
      4'b1101: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: r = x << sh;
      4'b1001: r = x >> sh;
      4'b1010: r = $signed(x) >>> sh;
      4'b0101: begin p = 64'(x) * 64'(y); r = p[31:0]; hi = p[63:32]; end
      4'b1011: begin
        if (y == 32'd0) begin r = 32'hFFFF_FFFF; hi = x; end
        else begin r = x / y; hi = x % y; end
      end
      4'b1110: begin
        hi = (y == 32'd0) ? x : x % y;
        r  = hi;
      end
      default: r = x + y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op == 4'b0101 || op == 4'b1011 || op == 4'b1110) ? W : 0;
  endfunction

  // Issue one op; lat = edges after the accept edge until done is seen, rlow = sampled cycles with ready low.
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int rlow);
    @(negedge clk);
    start = 1'b1; alu_control = op; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; rlow = 0;
    if (!ready) rlow++;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!ready && !done) rlow++;
    end
    a = $urandom; b = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== '0 || result_hi !== '0) begin errors++; $display("FAIL reset_result got %h/%h want 0/0", result, result_hi); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  ops [7]  = '{4'b0010, 4'b0101, 4'b1011, 4'b1011, 4'b1110, 4'b1010, 4'b0111};
    logic [31:0] xs  [7]  = '{32'd5, 32'hFFFF_FFFF, 32'd100, 32'd9, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] ys  [7]  = '{32'd7, 32'd2, 32'd7, 32'd0, 32'd7, 32'h80, 32'd1};
    logic [31:0] er  [7]  = '{32'd12, 32'hFFFF_FFFE, 32'd14, 32'hFFFF_FFFF, 32'd2, 32'hE000_0000, 32'd0};
    logic [31:0] eh  [7]  = '{32'd0, 32'd1, 32'd2, 32'd9, 32'd2, 32'd0, 32'd0};
    int lat, rlow;
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], xs[i], ys[i], lat, rlow);
      checks++; if (result !== er[i] || result_hi !== eh[i]) begin
        errors++; $display("FAIL directed%0d result got %h/%h want %h/%h", i, result_hi, result, eh[i], er[i]);
      end
      checks++; if (zero !== (er[i] == 32'd0)) begin errors++; $display("FAIL directed%0d zero got %b", i, zero); end
      checks++; if (lat !== exp_lat(ops[i]) || rlow !== exp_lat(ops[i])) begin
        errors++; $display("FAIL directed%0d latency got %0d ready_low %0d want %0d", i, lat, rlow, exp_lat(ops[i]));
      end
    end
    do_op(4'b1101, 32'hFFFF_FFFF, 32'd1, lat, rlow);
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt_signed got %h want 1", result); end
  endtask

  task automatic test_ignore_start();
    logic [31:0] x, y, er, eh, got_r, got_h;
    int ndone;
    x = 32'h1234_5678; y = 32'h9ABC_DEF1;
    model(4'b0101, x, y, er, eh);
    @(negedge clk);
    start = 1'b1; alu_control = 4'b0101; a = x; b = y;
    @(posedge clk);
    ndone = 0; got_r = '0; got_h = '0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done) begin ndone++; got_r = result; got_h = result_hi; end
      start = (i >= 2 && i <= 6);
      alu_control = 4'b0010; a = $urandom; b = $urandom;
    end
    start = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_start done_count got %0d want 1", ndone); end
    checks++; if (got_r !== er || got_h !== eh) begin
      errors++; $display("FAIL ignore_start product got %h_%h want %h_%h", got_h, got_r, eh, er);
    end
  endtask

  task automatic test_reset_mid_div();
    int ndone, lat, rlow;
    @(negedge clk);
    start = 1'b1; alu_control = 4'b1011; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mid_reset ready/done got %b/%b want 1/0", ready, done); end
    checks++; if (result !== '0 || result_hi !== '0 || zero !== 1'b1) begin
      errors++; $display("FAIL mid_reset outputs got %h/%h/%b want 0/0/1", result, result_hi, zero);
    end
    ndone = 0;
    repeat (W + 8) begin @(negedge clk); if (done) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL mid_reset stray_done got %0d want 0", ndone); end
    do_op(4'b1011, 32'd1000, 32'd3, lat, rlow);
    checks++; if (result !== 32'd333 || result_hi !== 32'd1 || lat !== W) begin
      errors++; $display("FAIL after_reset div got %0d r%0d lat %0d want 333 r1 lat %0d", result, result_hi, lat, W);
    end
    // start together with reset: the request must be dropped
    @(negedge clk);
    reset = 1'b1; start = 1'b1; alu_control = 4'b0101; a = 32'd3; b = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || done !== 1'b0 || result !== '0) begin
      errors++; $display("FAIL start_with_reset got ready %b done %b result %h want 1/0/0", ready, done, result);
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] x, y, er, eh;
    int lat, rlow;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 10 == 0) x = 32'($urandom_range(0, 3));
      model(op, x, y, er, eh);
      do_op(op, x, y, lat, rlow);
      checks++; if (result !== er || result_hi !== eh || zero !== (er == 32'd0)) begin
        errors++; $display("FAIL random op %b a %h b %h got %h/%h z%b want %h/%h", op, x, y, result_hi, result, zero, eh, er);
      end
      checks++; if (lat !== exp_lat(op) || rlow !== exp_lat(op)) begin
        errors++; $display("FAIL random_latency op %b got %0d ready_low %0d want %0d", op, lat, rlow, exp_lat(op));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [6], ys [6], er, eh;
    logic [3:0]  ops [6];
    for (int i = 0; i < 6; i++) begin
      xs[i] = $urandom; ys[i] = $urandom;
      ops[i] = (i % 2 == 0) ? 4'b0110 : 4'b0100;
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; alu_control = ops[i]; a = xs[i]; b = ys[i];
      @(negedge clk);
      model(ops[i], xs[i], ys[i], er, eh);
      checks++; if (done !== 1'b1 || ready !== 1'b1 || result !== er) begin
        errors++; $display("FAIL back_to_back%0d got done %b ready %b result %h want 1/1/%h", i, done, ready, result, er);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL back_to_back_tail done got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
